// File: rtl/osc_pkg.sv
// Shared oscilloscope definitions: DIP-switch mode codes, capture state codes
// and the default sample width used across the acquisition path.
package osc_pkg;

  localparam int unsigned DATA_W_DFLT = 8;

  localparam logic [1:0] MODE_STOP   = 2'b00;
  localparam logic [1:0] MODE_AUTO   = 2'b01;
  localparam logic [1:0] MODE_NORMAL = 2'b10;
  localparam logic [1:0] MODE_SINGLE = 2'b11;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_PRE_FILL  = 3'd1;
  localparam logic [2:0] S_WAIT_TRIG = 3'd2;
  localparam logic [2:0] S_POST_FILL = 3'd3;
  localparam logic [2:0] S_HOLD      = 3'd4;

endpackage

// File: rtl/capture_sequencer_if.sv
// Capture RAM write port: the sequencer drives it (master), the RAM consumes it (slave).
interface capture_sequencer_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 10
);

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  modport master (output wr_en, wr_addr, wr_data);
  modport slave  (input  wr_en, wr_addr, wr_data);

endinterface

// File: rtl/trigger_detect.sv
// Edge trigger compare against the previous valid sample; trig_hit is asserted in
// the cycle the qualifying sample is presented, so it commits on the same edge as its write.
module trigger_detect #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_data,
  input  logic [DATA_W-1:0] trig_level,
  input  logic              trig_rising,
  output logic              trig_hit
);

  logic [DATA_W-1:0] prev;

  always_comb begin
    trig_hit = 1'b0;
    if (sample_valid) begin
      if (trig_rising) begin
        trig_hit = (prev < trig_level) && (sample_data >= trig_level);
      end else begin
        trig_hit = (prev > trig_level) && (sample_data <= trig_level);
      end
    end
  end

  // prev tracks every valid sample, so the first compare after arming sees real history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev <= '0;
    end else if (sample_valid) begin
      prev <= sample_data;
    end
  end

endmodule

// File: rtl/capture_sequencer.sv
// Scope acquisition controller: pre-trigger fill, trigger search, post-trigger fill
// and frame hold over a circular capture RAM, driven by the DIP-switch mode.
module capture_sequencer
  import osc_pkg::*;
#(
  parameter int unsigned DATA_W       = DATA_W_DFLT,
  parameter int unsigned ADDR_W       = 10,
  parameter int unsigned PRE_TRIG     = 256,
  parameter int unsigned AUTO_TIMEOUT = 1000000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          mode,
  input  logic                sample_valid,
  input  logic [DATA_W-1:0]   sample_data,
  input  logic [DATA_W-1:0]   trig_level,
  input  logic                trig_rising,
  input  logic                disp_done,
  capture_sequencer_if.master ram,
  output logic                frame_ready,
  output logic [ADDR_W-1:0]   frame_start_addr,
  output logic                triggered,
  output logic                auto_fired,
  output logic [2:0]          state_dbg
);

  localparam int unsigned DEPTH  = 1 << ADDR_W;
  localparam int unsigned POST_N = DEPTH - PRE_TRIG - 1;
  localparam int unsigned TMO_W  = (AUTO_TIMEOUT > 1) ? $clog2(AUTO_TIMEOUT) : 1;

  localparam logic [ADDR_W-1:0] PRE_OFS   = ADDR_W'(PRE_TRIG);
  localparam logic [ADDR_W-1:0] PRE_LAST  = ADDR_W'(PRE_TRIG - 1);
  localparam logic [ADDR_W-1:0] POST_LAST = ADDR_W'((POST_N == 0) ? 0 : POST_N - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(AUTO_TIMEOUT - 1);

  logic [2:0]        state;
  logic [1:0]        mode_q;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] cnt;
  logic [TMO_W-1:0]  tmo;
  logic [ADDR_W-1:0] trig_addr;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;

  logic trig_hit;
  logic writing;
  logic timed_out;
  logic fire;
  logic rearm_ok;

  trigger_detect #(
    .DATA_W (DATA_W)
  ) u_trig (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .trig_level   (trig_level),
    .trig_rising  (trig_rising),
    .trig_hit     (trig_hit)
  );

  always_comb begin
    writing   = 1'b0;
    timed_out = 1'b0;
    fire      = 1'b0;
    rearm_ok  = 1'b0;
    if (sample_valid &&
        (state == S_PRE_FILL || state == S_WAIT_TRIG || state == S_POST_FILL)) begin
      writing = 1'b1;
    end
    if (mode_q == MODE_AUTO && tmo == TMO_LAST) begin
      timed_out = 1'b1;
    end
    if (writing && state == S_WAIT_TRIG && (trig_hit || timed_out)) begin
      fire = 1'b1;
    end
    if (mode_q == MODE_NORMAL || mode_q == MODE_AUTO) begin
      rearm_ok = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= S_IDLE;
      mode_q           <= MODE_STOP;
      ptr              <= '0;
      cnt              <= '0;
      tmo              <= '0;
      trig_addr        <= '0;
      wr_en_q          <= 1'b0;
      wr_addr_q        <= '0;
      wr_data_q        <= '0;
      frame_ready      <= 1'b0;
      frame_start_addr <= '0;
      triggered        <= 1'b0;
      auto_fired       <= 1'b0;
    end else begin
      mode_q  <= mode;
      wr_en_q <= 1'b0;
      // A mode change pre-empts every state action, including disp_done in HOLD
      if (mode != mode_q) begin
        state            <= S_IDLE;
        wr_addr_q        <= '0;
        wr_data_q        <= '0;
        frame_ready      <= 1'b0;
        frame_start_addr <= '0;
        triggered        <= 1'b0;
        auto_fired       <= 1'b0;
      end else begin
        if (writing) begin
          wr_en_q   <= 1'b1;
          wr_addr_q <= ptr;
          wr_data_q <= sample_data;
          ptr       <= ptr + 1'b1;
        end
        case (state)
          S_IDLE: begin
            ptr         <= '0;
            cnt         <= '0;
            tmo         <= '0;
            triggered   <= 1'b0;
            auto_fired  <= 1'b0;
            frame_ready <= 1'b0;
            if (mode != MODE_STOP) begin
              state <= S_PRE_FILL;
            end
          end
          S_PRE_FILL: begin
            if (writing) begin
              if (cnt == PRE_LAST) begin
                cnt   <= '0;
                tmo   <= '0;
                state <= S_WAIT_TRIG;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
          end
          S_WAIT_TRIG: begin
            if (tmo != TMO_LAST) begin
              tmo <= tmo + 1'b1;
            end
            if (fire) begin
              triggered  <= 1'b1;
              auto_fired <= !trig_hit;
              trig_addr  <= ptr;
              cnt        <= '0;
              // With PRE_TRIG = DEPTH-1 the trigger write itself completes the frame
              if (POST_N == 0) begin
                state            <= S_HOLD;
                frame_ready      <= 1'b1;
                frame_start_addr <= ptr - PRE_OFS;
              end else begin
                state <= S_POST_FILL;
              end
            end
          end
          S_POST_FILL: begin
            if (writing) begin
              if (cnt == POST_LAST) begin
                state            <= S_HOLD;
                frame_ready      <= 1'b1;
                frame_start_addr <= trig_addr - PRE_OFS;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
          end
          S_HOLD: begin
            if (disp_done && rearm_ok) begin
              frame_ready <= 1'b0;
              triggered   <= 1'b0;
              auto_fired  <= 1'b0;
              cnt         <= '0;
              state       <= S_PRE_FILL;
            end
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign ram.wr_en   = wr_en_q;
  assign ram.wr_addr = wr_addr_q;
  assign ram.wr_data = wr_data_q;
  assign state_dbg   = state;

endmodule

// File: tb/tb_capture_sequencer.sv
// Directed bench for capture_sequencer with a 16-entry buffer, 4 pre-trigger samples
// and a 20-cycle AUTO timeout.
module tb_capture_sequencer;

  logic       clk;
  logic       rst_n;
  logic [1:0] mode;
  logic       sample_valid;
  logic [7:0] sample_data;
  logic [7:0] trig_level;
  logic       trig_rising;
  logic       disp_done;
  logic       frame_ready;
  logic [3:0] frame_start_addr;
  logic       triggered;
  logic       auto_fired;
  logic [2:0] state_dbg;

  int checks = 0;
  int errors = 0;

  capture_sequencer_if #(.DATA_W(8), .ADDR_W(4)) ram_if ();

  capture_sequencer #(
    .DATA_W       (8),
    .ADDR_W       (4),
    .PRE_TRIG     (4),
    .AUTO_TIMEOUT (20)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .mode             (mode),
    .sample_valid     (sample_valid),
    .sample_data      (sample_data),
    .trig_level       (trig_level),
    .trig_rising      (trig_rising),
    .disp_done        (disp_done),
    .ram              (ram_if),
    .frame_ready      (frame_ready),
    .frame_start_addr (frame_start_addr),
    .triggered        (triggered),
    .auto_fired       (auto_fired),
    .state_dbg        (state_dbg)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [1:0] mode;
    logic       valid;
    logic [7:0] data;
    logic       disp;
    logic [2:0] st;
    logic       we;
    logic [3:0] wa;
    logic [7:0] wd;
    logic       fr;
    logic [3:0] fsa;
    logic       trg;
    logic       af;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input logic [1:0] m, input logic vl, input logic [7:0] d,
                             input logic dd, input logic [2:0] st, input logic we,
                             input logic [3:0] wa, input logic [7:0] wd, input logic fr,
                             input logic [3:0] fsa, input logic trg, input logic af);
    vec_t r;
    r.mode = m; r.valid = vl; r.data = d; r.disp = dd;
    r.st = st; r.we = we; r.wa = wa; r.wd = wd;
    r.fr = fr; r.fsa = fsa; r.trg = trg; r.af = af;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input logic [2:0] st, input int bound, input string name);
    int n;
    n = 0;
    while (state_dbg != st && n < bound) begin
      step();
      n++;
    end
    if (state_dbg != st) chk({name, " timeout"}, 32'(state_dbg), 32'(st));
  endtask

  task automatic do_reset();
    mode = 2'd0; sample_valid = 1'b0; sample_data = '0; disp_done = 1'b0;
    trig_level = 8'd10; trig_rising = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    bit fr_seen, wrap_seen;
    logic [3:0] last_wa;
    int n;

    // Test 1: NORMAL, rising ramp, level 10
    //          mode vl data dd  st we wa wd  fr fsa trg af
    tbl.push_back(v(2, 0,  0, 0,  0, 0, 0,  0, 0, 0, 0, 0));
    tbl.push_back(v(2, 0,  0, 0,  1, 0, 0,  0, 0, 0, 0, 0));
    tbl.push_back(v(2, 1,  0, 0,  1, 1, 0,  0, 0, 0, 0, 0));
    tbl.push_back(v(2, 1,  1, 0,  1, 1, 1,  1, 0, 0, 0, 0));
    tbl.push_back(v(2, 1,  2, 0,  1, 1, 2,  2, 0, 0, 0, 0));
    tbl.push_back(v(2, 1,  3, 0,  2, 1, 3,  3, 0, 0, 0, 0));
    tbl.push_back(v(2, 1,  4, 0,  2, 1, 4,  4, 0, 0, 0, 0));
    tbl.push_back(v(2, 1,  5, 0,  2, 1, 5,  5, 0, 0, 0, 0));
    tbl.push_back(v(2, 1,  6, 0,  2, 1, 6,  6, 0, 0, 0, 0));
    tbl.push_back(v(2, 1,  7, 0,  2, 1, 7,  7, 0, 0, 0, 0));
    tbl.push_back(v(2, 1,  8, 0,  2, 1, 8,  8, 0, 0, 0, 0));
    tbl.push_back(v(2, 1,  9, 0,  2, 1, 9,  9, 0, 0, 0, 0));
    tbl.push_back(v(2, 1, 10, 0,  3, 1, 10, 10, 0, 0, 1, 0));
    tbl.push_back(v(2, 1, 11, 0,  3, 1, 11, 11, 0, 0, 1, 0));
    tbl.push_back(v(2, 1, 12, 0,  3, 1, 12, 12, 0, 0, 1, 0));
    tbl.push_back(v(2, 1, 13, 0,  3, 1, 13, 13, 0, 0, 1, 0));
    tbl.push_back(v(2, 1, 14, 0,  3, 1, 14, 14, 0, 0, 1, 0));
    tbl.push_back(v(2, 1, 15, 0,  3, 1, 15, 15, 0, 0, 1, 0));
    tbl.push_back(v(2, 1, 16, 0,  3, 1, 0,  16, 0, 0, 1, 0));
    tbl.push_back(v(2, 1, 17, 0,  3, 1, 1,  17, 0, 0, 1, 0));
    tbl.push_back(v(2, 1, 18, 0,  3, 1, 2,  18, 0, 0, 1, 0));
    tbl.push_back(v(2, 1, 19, 0,  3, 1, 3,  19, 0, 0, 1, 0));
    tbl.push_back(v(2, 1, 20, 0,  3, 1, 4,  20, 0, 0, 1, 0));
    tbl.push_back(v(2, 1, 21, 0,  4, 1, 5,  21, 1, 6, 1, 0));
    tbl.push_back(v(2, 1, 22, 0,  4, 0, 5,  21, 1, 6, 1, 0));
    tbl.push_back(v(2, 1, 23, 0,  4, 0, 5,  21, 1, 6, 1, 0));

    rst_n = 1'b0;
    mode = 2'd0; sample_valid = 1'b0; sample_data = '0; disp_done = 1'b0;
    trig_level = 8'd10; trig_rising = 1'b1;
    #13;
    chk("reset state", 32'(state_dbg), 32'(0));
    chk("reset wr_en", 32'(ram_if.wr_en), 32'(0));
    chk("reset wr_addr", 32'(ram_if.wr_addr), 32'(0));
    chk("reset frame_ready", 32'(frame_ready), 32'(0));
    chk("reset triggered", 32'(triggered), 32'(0));
    chk("reset auto_fired", 32'(auto_fired), 32'(0));
    do_reset();

    foreach (tbl[i]) begin
      mode = tbl[i].mode; sample_valid = tbl[i].valid;
      sample_data = tbl[i].data; disp_done = tbl[i].disp;
      step();
      chk($sformatf("t1[%0d] state", i), 32'(state_dbg), 32'(tbl[i].st));
      chk($sformatf("t1[%0d] wr_en", i), 32'(ram_if.wr_en), 32'(tbl[i].we));
      chk($sformatf("t1[%0d] wr_addr", i), 32'(ram_if.wr_addr), 32'(tbl[i].wa));
      chk($sformatf("t1[%0d] wr_data", i), 32'(ram_if.wr_data), 32'(tbl[i].wd));
      chk($sformatf("t1[%0d] frame_ready", i), 32'(frame_ready), 32'(tbl[i].fr));
      chk($sformatf("t1[%0d] frame_start", i), 32'(frame_start_addr), 32'(tbl[i].fsa));
      chk($sformatf("t1[%0d] triggered", i), 32'(triggered), 32'(tbl[i].trg));
      chk($sformatf("t1[%0d] auto_fired", i), 32'(auto_fired), 32'(tbl[i].af));
    end

    // Test 2: NORMAL, constant below level: never triggers, pointer wraps
    do_reset();
    mode = 2'd2; sample_valid = 1'b1; sample_data = 8'd5;
    fr_seen = 1'b0; wrap_seen = 1'b0; last_wa = '0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (frame_ready) fr_seen = 1'b1;
      if (ram_if.wr_en && last_wa == 4'd15 && ram_if.wr_addr == 4'd0) wrap_seen = 1'b1;
      last_wa = ram_if.wr_addr;
    end
    chk("t2 frame_ready seen", 32'(fr_seen), 32'(0));
    chk("t2 wrap 15->0 seen", 32'(wrap_seen), 32'(1));
    chk("t2 state", 32'(state_dbg), 32'(2));
    chk("t2 triggered", 32'(triggered), 32'(0));

    // Test 3: AUTO, constant: forced trigger after 20 cycles in WAIT_TRIG
    do_reset();
    mode = 2'd1; sample_valid = 1'b1; sample_data = 8'd5;
    n = 0;
    for (int i = 0; i < 100 && state_dbg != 3'd3; i++) begin
      step();
      if (state_dbg == 3'd2) n++;
    end
    chk("t3 cycles in wait", 32'(n), 32'(20));
    chk("t3 state", 32'(state_dbg), 32'(3));
    chk("t3 auto_fired", 32'(auto_fired), 32'(1));
    chk("t3 triggered", 32'(triggered), 32'(1));
    chk("t3 trig wr_addr", 32'(ram_if.wr_addr), 32'(7));
    n = 0;
    for (int i = 0; i < 40 && !frame_ready; i++) begin
      step();
      n++;
    end
    chk("t3 post writes", 32'(n), 32'(11));
    chk("t3 frame_start", 32'(frame_start_addr), 32'(3));
    chk("t3 hold state", 32'(state_dbg), 32'(4));

    // Test 3b: real trigger on the timeout sample is not a forced trigger
    do_reset();
    mode = 2'd1; sample_valid = 1'b1; sample_data = 8'd5;
    n = 0;
    for (int i = 0; i < 100 && n < 20; i++) begin
      step();
      if (state_dbg == 3'd2) n++;
    end
    sample_data = 8'd10;
    step();
    chk("t3b state", 32'(state_dbg), 32'(3));
    chk("t3b triggered", 32'(triggered), 32'(1));
    chk("t3b auto_fired", 32'(auto_fired), 32'(0));
    chk("t3b trig data", 32'(ram_if.wr_data), 32'(10));

    // Test 4: SINGLE ignores disp_done; mode change leaves HOLD
    do_reset();
    mode = 2'd3; sample_valid = 1'b1; sample_data = 8'd0;
    for (int i = 0; i < 80 && !frame_ready; i++) begin
      step();
      sample_data = sample_data + 8'd1;
    end
    chk("t4 frame_ready", 32'(frame_ready), 32'(1));
    disp_done = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      disp_done = 1'b0;
      chk($sformatf("t4 hold[%0d] state", i), 32'(state_dbg), 32'(4));
      chk($sformatf("t4 hold[%0d] wr_en", i), 32'(ram_if.wr_en), 32'(0));
    end
    mode = 2'd2;
    step();
    chk("t4 abort state", 32'(state_dbg), 32'(0));
    chk("t4 abort frame_ready", 32'(frame_ready), 32'(0));
    step();
    chk("t4 restart state", 32'(state_dbg), 32'(1));

    // Test 5: NORMAL, falling edge on a ramp down from 20, then re-arm
    do_reset();
    mode = 2'd2; trig_rising = 1'b0;
    wait_state(3'd1, 5, "t5 pre_fill");
    sample_valid = 1'b1; sample_data = 8'd20;
    for (int i = 0; i < 40 && state_dbg != 3'd3; i++) begin
      step();
      if (state_dbg != 3'd3) sample_data = sample_data - 8'd1;
    end
    chk("t5 trig data", 32'(ram_if.wr_data), 32'(10));
    chk("t5 trig addr", 32'(ram_if.wr_addr), 32'(10));
    for (int i = 0; i < 30 && !frame_ready; i++) begin
      sample_data = (sample_data == 8'd0) ? 8'd0 : sample_data - 8'd1;
      step();
    end
    chk("t5 frame_ready", 32'(frame_ready), 32'(1));
    chk("t5 frame_start", 32'(frame_start_addr), 32'(6));
    disp_done = 1'b1;
    step();
    disp_done = 1'b0;
    chk("t5 rearm state", 32'(state_dbg), 32'(1));
    chk("t5 rearm frame_ready", 32'(frame_ready), 32'(0));

    // Test 7: crossings during PRE_FILL are ignored
    do_reset();
    mode = 2'd2; trig_level = 8'd2;
    wait_state(3'd1, 5, "t7 pre_fill");
    sample_valid = 1'b1; sample_data = 8'd0;
    for (int i = 0; i < 10; i++) begin
      step();
      sample_data = sample_data + 8'd1;
    end
    chk("t7 state", 32'(state_dbg), 32'(2));
    chk("t7 triggered", 32'(triggered), 32'(0));

    // Test 6: mode change mid POST_FILL, then async reset mid WAIT_TRIG
    do_reset();
    mode = 2'd2;
    wait_state(3'd1, 5, "t6 pre_fill");
    sample_valid = 1'b1; sample_data = 8'd0;
    for (int i = 0; i < 40 && state_dbg != 3'd3; i++) begin
      step();
      sample_data = sample_data + 8'd1;
    end
    repeat (3) begin
      step();
      sample_data = sample_data + 8'd1;
    end
    chk("t6 in post_fill", 32'(state_dbg), 32'(3));
    mode = 2'd1;
    step();
    chk("t6 abort state", 32'(state_dbg), 32'(0));
    chk("t6 abort wr_en", 32'(ram_if.wr_en), 32'(0));
    chk("t6 abort wr_addr", 32'(ram_if.wr_addr), 32'(0));
    chk("t6 abort wr_data", 32'(ram_if.wr_data), 32'(0));
    chk("t6 abort frame_ready", 32'(frame_ready), 32'(0));
    chk("t6 abort frame_start", 32'(frame_start_addr), 32'(0));
    chk("t6 abort triggered", 32'(triggered), 32'(0));
    chk("t6 abort auto_fired", 32'(auto_fired), 32'(0));
    step();
    chk("t6 restart state", 32'(state_dbg), 32'(1));
    wait_state(3'd2, 20, "t6 wait_trig");
    chk("t6 before reset wr_en", 32'(ram_if.wr_en), 32'(1));
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6 async reset state", 32'(state_dbg), 32'(0));
    chk("t6 async reset wr_en", 32'(ram_if.wr_en), 32'(0));
    chk("t6 async reset wr_addr", 32'(ram_if.wr_addr), 32'(0));
    #2;
    rst_n = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
